// File: rtl/photon_pkg.sv
// Shared types and constants for the multi-lane photonic tile.
// Holds the score width derivation, mode encodings, accumulator FSM states
// and the ADC-noise LFSR constants.
package photon_pkg;

  localparam logic PH_MODE_RAW = 1'b0;
  localparam logic PH_MODE_ACC = 1'b1;

  localparam logic [15:0] PH_LFSR_POLY = 16'hB400;
  localparam logic [15:0] PH_LFSR_SEED = 16'hACE1;

  typedef enum logic {
    ACC_IDLE = 1'b0,
    ACC_RUN  = 1'b1
  } ph_acc_state_t;

  // Product width, plus lane-sum growth, plus accumulation headroom.
  function automatic int ph_score_w(input int data_w, input int lanes, input int acc_beats_w);
    return 2 * data_w + $clog2(lanes) + acc_beats_w;
  endfunction

endpackage

// File: rtl/photon_score_fifo.sv
// Purpose: first-word fall-through score FIFO with occupancy count.
// Latency: a write is visible on rd_data the cycle after the write edge.
// Backpressure: none internally; the writer is credit-limited so it never overflows.
// Ports: wr_valid/wr_data push, rd_en pops the head, rd_data is the head (0 when empty),
//        count is the number of stored entries.
module photon_score_fifo #(
  parameter int WIDTH = 42,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_valid,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_pop;
  logic             do_push;

  assign do_pop  = rd_en && (count_q != '0);
  // A push into a full FIFO is fine when the head leaves on the same edge.
  assign do_push = wr_valid && ((count_q != FULL_CNT) || do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= wr_data;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      count_q <= count_q + (AW + 1)'(do_push) - (AW + 1)'(do_pop);
    end
  end

  assign rd_data = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
  assign count   = count_q;

endmodule

// File: rtl/photon_tile_mc.sv
// Purpose: multi-lane photonic dot-product tile: per-lane products, lane-sum, optional
//          cross-pulse accumulation, scores out through an FWFT FIFO.
// Latency: score visible OPTICAL_LATENCY+1 edges after the accept edge.
// Backpressure: optical pipe never stalls; fire_ready is a credit gate (inflight < FIFO_DEPTH).
// Ports: q_amplitude/k_phase packed lanes (lane 0 in LSBs), fire_valid/fire_ready/fire_last/mode
//        issue side; digital_score/score_valid/score_ready output side; inflight credit count;
//        mode_err sticky error (raw beat inside an open accumulation group).
// Option: define PHOTON_ADC_NOISE_EN to add LFSR quantisation noise (adds TILE_SEED parameter).
module photon_tile_mc
  import photon_pkg::*;
#(
  parameter int LANES           = 4,
  parameter int DATA_W          = 16,
  parameter int OPTICAL_LATENCY = 10,
  parameter int ACC_BEATS_W     = 8,
  parameter int FIFO_DEPTH      = 8,
`ifdef PHOTON_ADC_NOISE_EN
  parameter logic [15:0] TILE_SEED = 16'h0000,
`endif
  parameter int SCORE_W         = ph_score_w(DATA_W, LANES, ACC_BEATS_W)
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [LANES*DATA_W-1:0]          q_amplitude,
  input  logic [LANES*DATA_W-1:0]          k_phase,
  input  logic                             fire_valid,
  output logic                             fire_ready,
  input  logic                             fire_last,
  input  logic                             mode,
  output logic signed [SCORE_W-1:0]        digital_score,
  output logic                             score_valid,
  input  logic                             score_ready,
  output logic [$clog2(FIFO_DEPTH):0]      inflight,
  output logic                             mode_err
);

  localparam int PW = 2 * DATA_W;
  localparam int IW = $clog2(FIFO_DEPTH) + 1;
  localparam int L  = OPTICAL_LATENCY;
  localparam logic [IW-1:0] DEPTH_CNT = IW'(FIFO_DEPTH);

  logic signed [PW-1:0]      prod_d [LANES];
  logic signed [PW-1:0]      prod_q [L][LANES];
  logic [L-1:0]              vld_q;
  logic [L-1:0]              mode_q;
  logic [L-1:0]              last_q;

  logic signed [SCORE_W-1:0] lane_sum;
  logic signed [SCORE_W-1:0] sum_q;
  logic                      sum_vld_q;
  logic                      sum_mode_q;
  logic                      sum_last_q;

  ph_acc_state_t             state_q, state_d;
  logic signed [SCORE_W-1:0] acc_q, acc_d;
  logic signed [SCORE_W-1:0] emit_dat;
  logic                      emit;
  logic                      fold;
  logic                      err_set;
  logic                      mode_err_q;

  logic [IW-1:0]             inflight_q;
  logic [IW-1:0]             fifo_count;
  logic                      accept;
  logic                      pop;

  assign fire_ready  = (inflight_q < DEPTH_CNT);
  assign accept      = fire_valid && fire_ready;
  assign score_valid = (fifo_count != '0);
  assign pop         = score_valid && score_ready;

  // Sign-extend both operands to the product width; the low PW bits of the
  // unsigned product equal the two's complement product.
  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      prod_d[i] = {{DATA_W{q_amplitude[i*DATA_W+DATA_W-1]}}, q_amplitude[i*DATA_W +: DATA_W]} *
                  {{DATA_W{k_phase[i*DATA_W+DATA_W-1]}}, k_phase[i*DATA_W +: DATA_W]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q  <= '0;
      mode_q <= '0;
      last_q <= '0;
      for (int s = 0; s < L; s++) begin
        for (int i = 0; i < LANES; i++) begin
          prod_q[s][i] <= '0;
        end
      end
    end else begin
      vld_q[0]  <= accept;
      mode_q[0] <= mode;
      last_q[0] <= fire_last;
      for (int i = 0; i < LANES; i++) begin
        prod_q[0][i] <= prod_d[i];
      end
      for (int s = 1; s < L; s++) begin
        vld_q[s]  <= vld_q[s-1];
        mode_q[s] <= mode_q[s-1];
        last_q[s] <= last_q[s-1];
        for (int i = 0; i < LANES; i++) begin
          prod_q[s][i] <= prod_q[s-1][i];
        end
      end
    end
  end

`ifdef PHOTON_ADC_NOISE_EN
  logic [15:0] lfsr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q <= PH_LFSR_SEED ^ TILE_SEED;
    end else begin
      lfsr_q <= lfsr_q[0] ? ((lfsr_q >> 1) ^ PH_LFSR_POLY) : (lfsr_q >> 1);
    end
  end
`endif

  // Lane reduction of the last optical stage. With noise enabled each lane
  // takes a differently rotated LFSR view, shifted down to [-4,+3].
  always_comb begin
`ifdef PHOTON_ADC_NOISE_EN
    logic [15:0]        rot;
    logic signed [15:0] nz;
    rot = '0;
    nz  = '0;
`endif
    lane_sum = '0;
    for (int i = 0; i < LANES; i++) begin
      lane_sum = lane_sum + {{(SCORE_W-PW){prod_q[L-1][i][PW-1]}}, prod_q[L-1][i]};
`ifdef PHOTON_ADC_NOISE_EN
      rot      = (lfsr_q << ((3 * i) % 16)) | (lfsr_q >> (16 - ((3 * i) % 16)));
      nz       = $signed(rot) >>> 13;
      lane_sum = lane_sum + {{(SCORE_W-16){nz[15]}}, nz};
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q      <= '0;
      sum_vld_q  <= 1'b0;
      sum_mode_q <= 1'b0;
      sum_last_q <= 1'b0;
    end else begin
      sum_q      <= lane_sum;
      sum_vld_q  <= vld_q[L-1];
      sum_mode_q <= mode_q[L-1];
      sum_last_q <= last_q[L-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ACC_IDLE;
      acc_q      <= '0;
      mode_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      mode_err_q <= mode_err_q | err_set;
    end
  end

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    emit     = 1'b0;
    emit_dat = sum_q;
    fold     = 1'b0;
    err_set  = 1'b0;
    if (sum_vld_q) begin
      case (state_q)
        ACC_IDLE: begin
          if (sum_mode_q == PH_MODE_RAW || sum_last_q) begin
            emit = 1'b1;
          end else begin
            acc_d   = sum_q;
            fold    = 1'b1;
            state_d = ACC_RUN;
          end
        end
        ACC_RUN: begin
          if (sum_mode_q == PH_MODE_RAW) begin
            // Open group is abandoned; the raw beat still produces its score.
            err_set = 1'b1;
            emit    = 1'b1;
            acc_d   = '0;
            state_d = ACC_IDLE;
          end else if (sum_last_q) begin
            emit     = 1'b1;
            emit_dat = acc_q + sum_q;
            acc_d    = '0;
            state_d  = ACC_IDLE;
          end else begin
            acc_d = acc_q + sum_q;
            fold  = 1'b1;
          end
        end
        default: state_d = ACC_IDLE;
      endcase
    end
  end

  // A folded beat never reaches the FIFO, so its credit is returned at the fold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight_q <= '0;
    end else begin
      inflight_q <= inflight_q + IW'(accept) - IW'(pop) - IW'(fold);
    end
  end

  photon_score_fifo #(
    .WIDTH (SCORE_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_valid (emit),
    .wr_data  (emit_dat),
    .rd_en    (pop),
    .rd_data  (digital_score),
    .count    (fifo_count)
  );

  assign inflight = inflight_q;
  assign mode_err = mode_err_q;

endmodule
